lcd_sprite_engine: RTL and testbench
====================================

// Module: lcd_sprite_engine
// PURPOSE
//  Parametrised PCD8544 (84x48, 6 banks) command/pixel sequencer. Replaces the hard-coded draw FSMs.
//  Runs init+clear, draws a sprite from an external ROM at any column/bank with right/bottom clipping,
//  and draws an N-channel level-bar strip. Emits bytes plus D/C to the SPI master through a valid/ready handshake.
// PARAMETERS
//  VOP        7'h10  contrast; init sends 8'h80|VOP
//  N_SPRITES  4      sprites held in ROM
//  SPR_W      16     sprite width, columns
//  SPR_BANKS  3      sprite height, 8-pixel banks
//  N_CH       5      bar channels (hunger, rest, fun, health, mood)
//  LVL_W      4      bits per channel level
//  CH_W       16     columns per channel; N_CH*CH_W<=84
//  BAR_BANK   5      bank used by the bar strip
//  BAR_PAT    8'h3C  column pattern of a filled bar cell
// PORTS
//  clock       in   1    system clock
//  Reset       in   1    synchronous reset, active high
//  cmd_init    in   1    request: init sequence + clear 504 bytes
//  cmd_draw    in   1    request: draw sprite spr_sel at (spr_x, spr_bank)
//  cmd_bars    in   1    request: redraw bar strip from levels
//  spr_sel     in   $clog2(N_SPRITES)  sprite index
//  spr_x       in   7    top-left column, 0..83
//  spr_bank    in   3    top bank, 0..5
//  levels      in   N_CH*LVL_W  channel levels, ch0 in LSBs
//  rom_addr    out  $clog2(N_SPRITES*SPR_W*SPR_BANKS)  sel*SPR_W*SPR_BANKS + bank*SPR_W + col
//  rom_data    in   8    ROM byte, valid 1 cycle after rom_addr (synchronous ROM)
//  spi_data    out  8    byte to send
//  spi_dc      out  1    0=command, 1=data; qualified by spi_valid
//  spi_valid   out  1    byte offered
//  spi_ready   in   1    master accepts the byte this cycle
//  busy        out  1    sequence in progress
//  done        out  1    1-cycle pulse when a sequence completes
//  err         out  1    1-cycle pulse when a request is rejected
//  back        out  1    backlight, active low
// BEHAVIOUR
//  Reset: state IDLE; spi_valid=0, spi_data=0, spi_dc=0, busy=0, done=0, err=0, back=1, rom_addr=0, inited=0.
//   Reset mid-sequence aborts at once. The byte in flight is dropped. inited is cleared.
//  Handshake: a byte transfers when spi_valid&&spi_ready. spi_data and spi_dc are stable while spi_valid=1 and !spi_ready.
//   The next byte may be offered the cycle after a transfer. spi_valid never drops without a transfer.
//  Requests are sampled only in IDLE. Priority on simultaneous requests: init > draw > bars. Requests while busy are ignored, no err.
//   spr_sel, spr_x, spr_bank and levels are latched at acceptance. busy rises the cycle after acceptance.
//  Rejects, each giving an err pulse and staying IDLE:
//   draw or bars while inited=0; spr_x>83; spr_bank>5; spr_sel>=N_SPRITES.
//  FSM states: IDLE, INIT, CLEAR, SETXY, FETCH, SEND, BARS, FINISH.
//   INIT: commands 21, 80|VOP, 20, 0C (dc=0).
//   CLEAR: commands 80, 40, then 504 data 00 (dc=1). Then inited=1 and back=0.
//   Draw: for each bank b in 0..SPR_BANKS-1 with spr_bank+b<=5:
//    send commands 80|spr_x and 40|(spr_bank+b), then the columns c with spr_x+c<=83.
//    Each column: FETCH puts rom_addr out; SEND offers rom_data captured on the next cycle, dc=1.
//    Clipped columns and banks are skipped; no bytes are sent for them.
//   BARS: commands 80, 40|BAR_BANK, then N_CH*CH_W data bytes.
//    Channel k, column c: BAR_PAT if c < min(level_k, CH_W-1), else 00. Column CH_W-1 is always the 00 gap.
//   FINISH: done=1 for one cycle, busy=0, return to IDLE.
//  Counters are sized for 504. The column index never wraps past 83.
// TESTING
//  T1 cmd_init, spi_ready=1 -> bytes 21,90,20,0C (dc=0), 80,40, then 504x00 (dc=1); done once; back=0.
//  T2 cmd_draw before any init -> err pulse, no spi_valid, busy stays 0.
//  T3 ROM byte=addr, spr_sel=1, spr_x=10, spr_bank=1 -> per bank: 8A, 41+b, then 16 bytes 48+16b..63+16b, b=0..2.
//  T4 spr_x=76, spr_bank=4 -> banks 4,5 only; 8 columns each; 16 data bytes total.
//  T5 spi_ready random 30% -> data and dc stable while stalled; byte sequence equals T3's.
//  T6 levels ch0=3, ch1=15, others 0 -> ch0 3x3C then 13x00; ch1 15x3C then 00; Reset mid-BARS -> IDLE, a later cmd_draw is rejected.

Source files
------------

// File: rtl/lcd_sprite_engine_if.sv
// SPI byte stream and sprite ROM bus between the sprite engine and its peers.
// The engine is the master: it offers bytes to the SPI side and addresses the ROM.
interface lcd_sprite_engine_if #(
  parameter int ROM_AW = 8
);
  logic [7:0]        spi_data;
  logic              spi_dc;
  logic              spi_valid;
  logic              spi_ready;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;

  modport master (
    output spi_data, spi_dc, spi_valid, rom_addr,
    input  spi_ready, rom_data
  );

  modport slave (
    input  spi_data, spi_dc, spi_valid, rom_addr,
    output spi_ready, rom_data
  );
endinterface

// File: rtl/lcd_sprite_engine.sv
// PCD8544 command/pixel sequencer: init+clear, clipped sprite draw from a
// synchronous ROM, and a level-bar strip, streamed over a valid/ready byte link.
module lcd_sprite_engine #(
  parameter logic [6:0] VOP       = 7'h10,
  parameter int         N_SPRITES = 4,
  parameter int         SPR_W     = 16,
  parameter int         SPR_BANKS = 3,
  parameter int         N_CH      = 5,
  parameter int         LVL_W     = 4,
  parameter int         CH_W      = 16,
  parameter int         BAR_BANK  = 5,
  parameter logic [7:0] BAR_PAT   = 8'h3C
) (
  input  logic                         clock,
  input  logic                         Reset,
  input  logic                         cmd_init,
  input  logic                         cmd_draw,
  input  logic                         cmd_bars,
  input  logic [$clog2(N_SPRITES)-1:0] spr_sel,
  input  logic [6:0]                   spr_x,
  input  logic [2:0]                   spr_bank,
  input  logic [N_CH*LVL_W-1:0]        levels,
  lcd_sprite_engine_if.master          bus,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         back
);
  localparam int ROM_AW = $clog2(N_SPRITES*SPR_W*SPR_BANKS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] INIT   = 3'd1;
  localparam logic [2:0] CLEAR  = 3'd2;
  localparam logic [2:0] SETXY  = 3'd3;
  localparam logic [2:0] FETCH  = 3'd4;
  localparam logic [2:0] SEND   = 3'd5;
  localparam logic [2:0] BARS   = 3'd6;
  localparam logic [2:0] FINISH = 3'd7;

  logic [2:0]                   state;
  logic                         inited;
  logic [9:0]                   idx;
  logic [6:0]                   col;
  logic [3:0]                   bnk;
  logic [3:0]                   ch;
  logic                         rom_wait;
  logic [$clog2(N_SPRITES)-1:0] sel_q;
  logic [6:0]                   x_q;
  logic [2:0]                   bank_q;
  logic [N_CH*LVL_W-1:0]        levels_q;

  logic [7:0] offer_data;
  logic       offer_dc;
  logic [3:0] cur_bank;
  logic       xfer;
  logic       col_more;
  logic       bank_more;
  int         bar_lvl;
  int         bar_lim;

  assign xfer      = bus.spi_valid && bus.spi_ready;
  assign cur_bank  = 4'(bank_q) + bnk;
  assign col_more  = (col < 7'(SPR_W-1)) && (8'(x_q) + 8'(col) + 8'd1 <= 8'd83);
  assign bank_more = (bnk < 4'(SPR_BANKS-1)) && (cur_bank + 4'd1 <= 4'd5);

  // Byte the current state would offer next, with its D/C flag.
  always_comb begin
    offer_data = 8'h00;
    offer_dc   = 1'b0;
    bar_lvl    = 0;
    bar_lim    = 0;
    case (state)
      INIT: begin
        case (idx[1:0])
          2'd0:    offer_data = 8'h21;
          2'd1:    offer_data = {1'b1, VOP};
          2'd2:    offer_data = 8'h20;
          default: offer_data = 8'h0C;
        endcase
      end
      CLEAR: begin
        if (idx == 10'd0)      offer_data = 8'h80;
        else if (idx == 10'd1) offer_data = 8'h40;
        else                   offer_dc   = 1'b1;
      end
      SETXY: begin
        if (idx == 10'd0) offer_data = {1'b1, x_q};
        else              offer_data = 8'h40 | {5'd0, cur_bank[2:0]};
      end
      SEND: begin
        offer_data = bus.rom_data;
        offer_dc   = 1'b1;
      end
      BARS: begin
        if (idx == 10'd0) begin
          offer_data = 8'h80;
        end else if (idx == 10'd1) begin
          offer_data = 8'h40 | {5'd0, 3'(BAR_BANK)};
        end else begin
          bar_lvl    = int'(levels_q[int'(ch)*LVL_W +: LVL_W]);
          bar_lim    = (bar_lvl < CH_W-1) ? bar_lvl : CH_W-1;
          offer_data = (int'(col) < bar_lim) ? BAR_PAT : 8'h00;
          offer_dc   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer: accepts requests in IDLE, walks each sequence one handshaken byte at a time.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state         <= IDLE;
      bus.spi_valid <= 1'b0;
      bus.spi_data  <= 8'h00;
      bus.spi_dc    <= 1'b0;
      bus.rom_addr  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      back          <= 1'b1;
      inited        <= 1'b0;
      idx           <= '0;
      col           <= '0;
      bnk           <= '0;
      ch            <= '0;
      rom_wait      <= 1'b0;
      sel_q         <= '0;
      x_q           <= '0;
      bank_q        <= '0;
      levels_q      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          idx <= '0;
          col <= '0;
          bnk <= '0;
          ch  <= '0;
          if (cmd_init) begin
            busy  <= 1'b1;
            state <= INIT;
          end else if (cmd_draw) begin
            if (!inited || spr_x > 7'd83 || spr_bank > 3'd5 || int'(spr_sel) >= N_SPRITES) begin
              err <= 1'b1;
            end else begin
              sel_q  <= spr_sel;
              x_q    <= spr_x;
              bank_q <= spr_bank;
              busy   <= 1'b1;
              state  <= SETXY;
            end
          end else if (cmd_bars) begin
            if (!inited) begin
              err <= 1'b1;
            end else begin
              levels_q <= levels;
              busy     <= 1'b1;
              state    <= BARS;
            end
          end
        end
        INIT: begin
          if (xfer) begin
            bus.spi_valid <= 1'b0;
            if (idx == 10'd3) begin
              idx   <= '0;
              state <= CLEAR;
            end else begin
              idx <= idx + 10'd1;
            end
          end else if (!bus.spi_valid) begin
            bus.spi_data  <= offer_data;
            bus.spi_dc    <= offer_dc;
            bus.spi_valid <= 1'b1;
          end
        end
        CLEAR: begin
          if (xfer) begin
            bus.spi_valid <= 1'b0;
            if (idx == 10'd505) begin
              inited <= 1'b1;
              back   <= 1'b0;
              state  <= FINISH;
            end else begin
              idx <= idx + 10'd1;
            end
          end else if (!bus.spi_valid) begin
            bus.spi_data  <= offer_data;
            bus.spi_dc    <= offer_dc;
            bus.spi_valid <= 1'b1;
          end
        end
        SETXY: begin
          if (xfer) begin
            bus.spi_valid <= 1'b0;
            if (idx == 10'd0) begin
              idx <= 10'd1;
            end else begin
              idx   <= '0;
              col   <= '0;
              state <= FETCH;
            end
          end else if (!bus.spi_valid) begin
            bus.spi_data  <= offer_data;
            bus.spi_dc    <= offer_dc;
            bus.spi_valid <= 1'b1;
          end
        end
        FETCH: begin
          bus.rom_addr <= ROM_AW'(int'(sel_q)*SPR_W*SPR_BANKS + int'(bnk)*SPR_W + int'(col));
          rom_wait     <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          if (rom_wait) begin
            rom_wait <= 1'b0;
          end else if (xfer) begin
            bus.spi_valid <= 1'b0;
            if (col_more) begin
              col   <= col + 7'd1;
              state <= FETCH;
            end else if (bank_more) begin
              bnk   <= bnk + 4'd1;
              idx   <= '0;
              state <= SETXY;
            end else begin
              state <= FINISH;
            end
          end else if (!bus.spi_valid) begin
            bus.spi_data  <= offer_data;
            bus.spi_dc    <= offer_dc;
            bus.spi_valid <= 1'b1;
          end
        end
        BARS: begin
          if (xfer) begin
            bus.spi_valid <= 1'b0;
            if (idx < 10'd2) begin
              idx <= idx + 10'd1;
            end else if (col == 7'(CH_W-1)) begin
              col <= '0;
              if (ch == 4'(N_CH-1)) state <= FINISH;
              else                  ch    <= ch + 4'd1;
            end else begin
              col <= col + 7'd1;
            end
          end else if (!bus.spi_valid) begin
            bus.spi_data  <= offer_data;
            bus.spi_dc    <= offer_dc;
            bus.spi_valid <= 1'b1;
          end
        end
        default: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_sprite_engine.sv
// Self-checking bench for lcd_sprite_engine: byte streams are compared against
// sequences built from the display rules with plain loops.
module tb_lcd_sprite_engine;
  localparam int N_CH  = 5;
  localparam int LVL_W = 4;
  localparam int CH_W  = 16;

  logic        clock = 1'b0;
  logic        Reset;
  logic        cmd_init, cmd_draw, cmd_bars;
  logic [1:0]  spr_sel;
  logic [6:0]  spr_x;
  logic [2:0]  spr_bank;
  logic [19:0] levels;
  logic        busy, done, err, back;

  int checks = 0;
  int passes = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int done_cnt = 0, err_cnt = 0, valid_cyc = 0, busy_cyc = 0, stall_viol = 0;
  bit ready_rand = 1'b0;
  bit have_stall = 1'b0;
  logic [7:0] st_data;
  logic       st_dc;

  always #5 clock = ~clock;

  lcd_sprite_engine_if #(.ROM_AW(8)) bus();

  lcd_sprite_engine dut (
    .clock(clock), .Reset(Reset),
    .cmd_init(cmd_init), .cmd_draw(cmd_draw), .cmd_bars(cmd_bars),
    .spr_sel(spr_sel), .spr_x(spr_x), .spr_bank(spr_bank), .levels(levels),
    .bus(bus), .busy(busy), .done(done), .err(err), .back(back)
  );

  // Synchronous ROM whose content is its own address.
  always @(posedge clock) bus.rom_data <= bus.rom_addr;

  // SPI master readiness: always ready, or ready about 30% of cycles.
  initial begin
    bus.spi_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      bus.spi_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Observe transfers, pulses and stall stability mid-cycle.
  always @(negedge clock) begin
    if (Reset) begin
      have_stall = 1'b0;
    end else begin
      if (have_stall && (!bus.spi_valid || bus.spi_data !== st_data || bus.spi_dc !== st_dc))
        stall_viol++;
      if (bus.spi_valid) valid_cyc++;
      if (bus.spi_valid && bus.spi_ready) got_q.push_back({bus.spi_dc, bus.spi_data});
      have_stall = bus.spi_valid && !bus.spi_ready;
      st_data = bus.spi_data;
      st_dc = bus.spi_dc;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (busy) busy_cyc++;
    end
  end

  function automatic int first_diff(int start);
    int n = got_q.size() - start;
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (got_q[start+i] !== exp_q[i]) return i;
    if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
    return -1;
  endfunction

  function automatic logic [8:0] got_at(int i);
    return (i >= 0 && i < got_q.size()) ? got_q[i] : 9'h1FF;
  endfunction

  function automatic logic [8:0] exp_at(int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 9'h1FF;
  endfunction

  function automatic void model_init();
    exp_q.delete();
    exp_q.push_back(9'h021); exp_q.push_back(9'h090);
    exp_q.push_back(9'h020); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h080); exp_q.push_back(9'h040);
    for (int i = 0; i < 504; i++) exp_q.push_back(9'h100);
  endfunction

  function automatic void model_draw(int sel, int x, int bank);
    exp_q.delete();
    for (int b = 0; b < 3; b++) begin
      if (bank + b > 5) break;
      exp_q.push_back({1'b0, 8'(8'h80 | x)});
      exp_q.push_back({1'b0, 8'(8'h40 | (bank + b))});
      for (int c = 0; c < 16; c++) begin
        if (x + c > 83) break;
        exp_q.push_back({1'b1, 8'((sel*48 + b*16 + c) % 256)});
      end
    end
  endfunction

  function automatic void model_bars(logic [19:0] lv);
    int lvl, lim;
    exp_q.delete();
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h045);
    for (int k = 0; k < N_CH; k++) begin
      lvl = int'((lv >> (k*LVL_W)) & 20'hF);
      lim = (lvl < CH_W-1) ? lvl : CH_W-1;
      for (int c = 0; c < CH_W; c++) exp_q.push_back({1'b1, (c < lim) ? 8'h3C : 8'h00});
    end
  endfunction

  task automatic pulse_cmd(input int which);
    @(posedge clock); #1;
    cmd_init = (which == 0);
    cmd_draw = (which == 1);
    cmd_bars = (which == 2);
    @(posedge clock); #1;
    cmd_init = 1'b0; cmd_draw = 1'b0; cmd_bars = 1'b0;
  endtask

  task automatic run_cmd(input int which, input int budget, output bit ok, output int start);
    int d0;
    start = got_q.size();
    d0 = done_cnt;
    ok = 1'b0;
    pulse_cmd(which);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    cmd_init = 1'b0; cmd_draw = 1'b0; cmd_bars = 1'b0;
    spr_sel = 2'd0; spr_x = 7'd0; spr_bank = 3'd0; levels = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.spi_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", bus.spi_valid); else passes++;
    checks++; if (bus.spi_data !== 8'h00) $display("[TB] FAIL reset_data got %h want 00", bus.spi_data); else passes++;
    checks++; if (bus.spi_dc !== 1'b0) $display("[TB] FAIL reset_dc got %b want 0", bus.spi_dc); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0 || err !== 1'b0) $display("[TB] FAIL reset_pulses got done=%b err=%b want 0 0", done, err); else passes++;
    checks++; if (back !== 1'b1) $display("[TB] FAIL reset_back got %b want 1", back); else passes++;
    checks++; if (bus.rom_addr !== 8'h00) $display("[TB] FAIL reset_rom_addr got %h want 00", bus.rom_addr); else passes++;
    @(posedge clock); #1;
    Reset = 1'b0;
  endtask

  task automatic test_uninit_reject();
    int e0 = err_cnt, v0 = valid_cyc, b0 = busy_cyc;
    spr_sel = 2'd1; spr_x = 7'd10; spr_bank = 3'd1;
    pulse_cmd(1);
    repeat (5) @(negedge clock);
    pulse_cmd(2);
    repeat (5) @(negedge clock);
    checks++; if (err_cnt - e0 !== 2) $display("[TB] FAIL uninit_err got %0d pulses want 2", err_cnt - e0); else passes++;
    checks++; if (valid_cyc - v0 !== 0) $display("[TB] FAIL uninit_valid got %0d valid cycles want 0", valid_cyc - v0); else passes++;
    checks++; if (busy_cyc - b0 !== 0) $display("[TB] FAIL uninit_busy got %0d busy cycles want 0", busy_cyc - b0); else passes++;
  endtask

  task automatic test_init();
    bit ok; int start, d, d0;
    d0 = done_cnt;
    model_init();
    run_cmd(0, 3000, ok, start);
    checks++; if (!ok) $display("[TB] FAIL init_timeout got no done want done"); else passes++;
    d = first_diff(start);
    checks++; if (d != -1) $display("[TB] FAIL init_seq at %0d got %h want %h", d, got_at(start+d), exp_at(d)); else passes++;
    checks++; if (done_cnt - d0 !== 1) $display("[TB] FAIL init_done got %0d pulses want 1", done_cnt - d0); else passes++;
    checks++; if (back !== 1'b0) $display("[TB] FAIL init_back got %b want 0", back); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL init_busy_after got %b want 0", busy); else passes++;
  endtask

  task automatic test_draw();
    bit ok; int start, d;
    spr_sel = 2'd1; spr_x = 7'd10; spr_bank = 3'd1;
    model_draw(1, 10, 1);
    run_cmd(1, 2000, ok, start);
    checks++; if (!ok) $display("[TB] FAIL draw_timeout got no done want done"); else passes++;
    d = first_diff(start);
    checks++; if (d != -1) $display("[TB] FAIL draw_seq at %0d got %h want %h", d, got_at(start+d), exp_at(d)); else passes++;
    checks++; if (got_at(start+2) !== 9'h130) $display("[TB] FAIL draw_first_data got %h want 130", got_at(start+2)); else passes++;
  endtask

  task automatic test_draw_clip();
    bit ok; int start, d, ndata;
    spr_sel = 2'd0; spr_x = 7'd76; spr_bank = 3'd4;
    model_draw(0, 76, 4);
    run_cmd(1, 2000, ok, start);
    checks++; if (!ok) $display("[TB] FAIL clip_timeout got no done want done"); else passes++;
    d = first_diff(start);
    checks++; if (d != -1) $display("[TB] FAIL clip_seq at %0d got %h want %h", d, got_at(start+d), exp_at(d)); else passes++;
    ndata = 0;
    for (int i = start; i < got_q.size(); i++) if (got_q[i][8]) ndata++;
    checks++; if (ndata !== 16) $display("[TB] FAIL clip_data_count got %0d want 16", ndata); else passes++;
  endtask

  task automatic test_bad_args();
    int e0 = err_cnt, v0 = valid_cyc, d0 = done_cnt;
    spr_sel = 2'd0; spr_x = 7'(84 + $urandom_range(0, 43)); spr_bank = 3'd0;
    pulse_cmd(1);
    repeat (4) @(negedge clock);
    spr_x = 7'd0; spr_bank = 3'(6 + $urandom_range(0, 1));
    pulse_cmd(1);
    repeat (4) @(negedge clock);
    checks++; if (err_cnt - e0 !== 2) $display("[TB] FAIL badarg_err got %0d pulses want 2", err_cnt - e0); else passes++;
    checks++; if (valid_cyc - v0 !== 0 || done_cnt - d0 !== 0) $display("[TB] FAIL badarg_quiet got valid=%0d done=%0d want 0 0", valid_cyc - v0, done_cnt - d0); else passes++;
  endtask

  task automatic test_stall();
    bit ok; int start, d, s0, sel, x, bank;
    ready_rand = 1'b1;
    s0 = stall_viol;
    spr_sel = 2'd1; spr_x = 7'd10; spr_bank = 3'd1;
    model_draw(1, 10, 1);
    run_cmd(1, 6000, ok, start);
    checks++; if (!ok) $display("[TB] FAIL stall_timeout got no done want done"); else passes++;
    d = first_diff(start);
    checks++; if (d != -1) $display("[TB] FAIL stall_seq at %0d got %h want %h", d, got_at(start+d), exp_at(d)); else passes++;
    for (int r = 0; r < 4; r++) begin
      sel = $urandom_range(0, 3); x = $urandom_range(0, 83); bank = $urandom_range(0, 5);
      spr_sel = 2'(sel); spr_x = 7'(x); spr_bank = 3'(bank);
      model_draw(sel, x, bank);
      run_cmd(1, 6000, ok, start);
      d = first_diff(start);
      checks++; if (!ok || d != -1) $display("[TB] FAIL rand_draw sel=%0d x=%0d bank=%0d at %0d got %h want %h", sel, x, bank, d, got_at(start+d), exp_at(d)); else passes++;
    end
    checks++; if (stall_viol - s0 !== 0) $display("[TB] FAIL stall_stable got %0d violations want 0", stall_viol - s0); else passes++;
    ready_rand = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok; int start, d, e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    spr_sel = 2'd2; spr_x = 7'd40; spr_bank = 3'd0;
    model_draw(2, 40, 0);
    start = got_q.size();
    pulse_cmd(1);
    repeat (3) @(negedge clock);
    pulse_cmd(2);
    pulse_cmd(0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clock);
    d = first_diff(start);
    checks++; if (!ok || d != -1) $display("[TB] FAIL busy_ignore_seq at %0d got %h want %h", d, got_at(start+d), exp_at(d)); else passes++;
    checks++; if (err_cnt - e0 !== 0 || done_cnt - d0 !== 1) $display("[TB] FAIL busy_ignore_pulses got err=%0d done=%0d want 0 1", err_cnt - e0, done_cnt - d0); else passes++;
  endtask

  task automatic test_bars();
    bit ok; int start, d, e0, v0;
    levels = 20'h000F3;
    model_bars(levels);
    run_cmd(2, 2000, ok, start);
    d = first_diff(start);
    checks++; if (!ok || d != -1) $display("[TB] FAIL bars_seq at %0d got %h want %h", d, got_at(start+d), exp_at(d)); else passes++;
    for (int r = 0; r < 2; r++) begin
      levels = 20'($urandom);
      model_bars(levels);
      run_cmd(2, 2000, ok, start);
      d = first_diff(start);
      checks++; if (!ok || d != -1) $display("[TB] FAIL rand_bars lv=%h at %0d got %h want %h", levels, d, got_at(start+d), exp_at(d)); else passes++;
    end
    pulse_cmd(2);
    repeat (15) @(posedge clock);
    #1; Reset = 1'b1;
    @(posedge clock); #1; Reset = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || bus.spi_valid !== 1'b0) $display("[TB] FAIL midreset_idle got busy=%b valid=%b want 0 0", busy, bus.spi_valid); else passes++;
    checks++; if (back !== 1'b1) $display("[TB] FAIL midreset_back got %b want 1", back); else passes++;
    e0 = err_cnt; v0 = valid_cyc;
    spr_sel = 2'd0; spr_x = 7'd0; spr_bank = 3'd0;
    pulse_cmd(1);
    repeat (5) @(negedge clock);
    checks++; if (err_cnt - e0 !== 1 || valid_cyc - v0 !== 0) $display("[TB] FAIL midreset_reject got err=%0d valid=%0d want 1 0", err_cnt - e0, valid_cyc - v0); else passes++;
  endtask

  initial begin
    test_reset();
    test_uninit_reject();
    test_init();
    test_draw();
    test_draw_clip();
    test_bad_args();
    test_stall();
    test_back_to_back();
    test_bars();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
